timer_controller: RTL and testbench

- Programmable down-counting timer controller for the KGP-RISC core.
- Sequences the cycle counter resource: holds the CPU-written configuration, prescaler and reload value, and emits tick and interrupt.
- Sits on the core's register write/read path, addressed by a 2-bit register select.
- Supports one-shot and periodic modes, pause/resume, and sticky expiry/overrun status.

---
 rtl/timer_controller.sv | 161 ++++++++++++++++
 tb/tb_timer_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_controller.sv
// Programmable down-counting timer for the KGP-RISC core: CTRL/LOAD/PRESCALE/STATUS
// registers, prescaled countdown, one-shot or periodic expiry with tick and interrupt.
module timer_controller #(
    parameter int CW = 32,
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [1:0]    addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [CW-1:0] count,
    output logic          tick,
    output logic          irq,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LOAD   = 2'd1;
    localparam logic [1:0] A_PSC    = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    state_t        state_r, state_nx_s;
    logic [3:0]    ctrl_r, ctrl_nx_s;
    logic [CW-1:0] load_r, count_r, count_nx_s;
    logic [PW-1:0] psc_r, psc_cnt_r, psc_cnt_nx_s;
    logic          expired_r, expired_nx_s;
    logic          overrun_r, overrun_nx_s;
    logic          tick_r, expiry_s;
    logic          ctrl_wr_s, load_wr_s, psc_wr_s, status_wr_s;

    assign ctrl_wr_s   = wr_en && (addr == A_CTRL);
    assign load_wr_s   = wr_en && (addr == A_LOAD);
    assign psc_wr_s    = wr_en && (addr == A_PSC);
    assign status_wr_s = wr_en && (addr == A_STATUS);

    // Next-state: control FSM, prescaler/counter sequencing and expiry detection
    always_comb begin
        state_nx_s   = state_r;
        count_nx_s   = count_r;
        psc_cnt_nx_s = psc_cnt_r;
        expiry_s     = 1'b0;
        ctrl_nx_s    = ctrl_wr_s ? wdata[3:0] : ctrl_r;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_wr_s && wdata[0] && !ctrl_r[0]) begin
                    count_nx_s   = load_r;
                    psc_cnt_nx_s = psc_r;
                    state_nx_s   = wdata[3] ? ST_HALT : ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A disable or pause write takes priority over any count step on the same edge
                if (ctrl_wr_s && !wdata[0]) begin
                    state_nx_s = ST_IDLE;
                end else if (ctrl_wr_s && wdata[3]) begin
                    state_nx_s = ST_HALT;
                end else if (psc_cnt_r != '0) begin
                    psc_cnt_nx_s = psc_cnt_r - PW'(1);
                end else begin
                    psc_cnt_nx_s = psc_r;
                    if (count_r != '0) begin
                        count_nx_s = count_r - CW'(1);
                    end else begin
                        expiry_s = 1'b1;
                        if (ctrl_r[1]) begin
                            count_nx_s = load_r;
                        end else begin
                            ctrl_nx_s[0] = 1'b0;
                            state_nx_s   = ST_IDLE;
                        end
                    end
                end
            end
            ST_HALT: begin
                if (ctrl_wr_s && !wdata[0]) begin
                    state_nx_s = ST_IDLE;
                end else if (ctrl_wr_s && !wdata[3]) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_HALT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Sticky status: a set on expiry beats a simultaneous write-1-to-clear
    always_comb begin
        expired_nx_s = expired_r;
        overrun_nx_s = overrun_r;
        if (expiry_s) begin
            expired_nx_s = 1'b1;
        end else if (status_wr_s && wdata[0]) begin
            expired_nx_s = 1'b0;
        end else begin
            expired_nx_s = expired_r;
        end
        if (expiry_s && expired_r) begin
            overrun_nx_s = 1'b1;
        end else if (status_wr_s && wdata[2]) begin
            overrun_nx_s = 1'b0;
        end else begin
            overrun_nx_s = overrun_r;
        end
    end

    // State and register file update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            ctrl_r    <= 4'd0;
            load_r    <= '0;
            psc_r     <= '0;
            count_r   <= '0;
            psc_cnt_r <= '0;
            expired_r <= 1'b0;
            overrun_r <= 1'b0;
            tick_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            ctrl_r    <= ctrl_nx_s;
            load_r    <= load_wr_s ? wdata[CW-1:0] : load_r;
            psc_r     <= psc_wr_s ? wdata[PW-1:0] : psc_r;
            count_r   <= count_nx_s;
            psc_cnt_r <= psc_cnt_nx_s;
            expired_r <= expired_nx_s;
            overrun_r <= overrun_nx_s;
            tick_r    <= expiry_s;
        end
    end

    // Register read mux
    always_comb begin
        rdata = 32'd0;
        case (addr)
            A_CTRL:   rdata = {28'd0, ctrl_r};
            A_LOAD:   rdata = 32'(load_r);
            A_PSC:    rdata = 32'(psc_r);
            A_STATUS: rdata = {29'd0, overrun_r, (state_r == ST_RUN), expired_r};
            default:  rdata = 32'd0;
        endcase
    end

    assign count = count_r;
    assign tick  = tick_r;
    assign busy  = (state_r == ST_RUN);
    assign irq   = expired_r & ctrl_r[2];

endmodule

// File: tb/tb_timer_controller.sv
// Bench for timer_controller: vector table, directed corner sequences and a
// randomized phase checked against a cycle-level reference model.
module tb_timer_controller;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] count;
    logic        tick;
    logic        irq;
    logic        busy;

    int total = 0;
    int bad   = 0;

    timer_controller #(.CW(32), .PW(16)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .count(count), .tick(tick), .irq(irq), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state (mode: 0 idle, 1 run, 2 halt)
    int          m_mode;
    logic [3:0]  m_ctrl;
    logic [31:0] m_load;
    logic [15:0] m_presc;
    logic [31:0] m_count;
    logic [15:0] m_psc;
    bit          m_exp, m_ovr, m_tick;

    task automatic model_reset();
        m_mode = 0; m_ctrl = 4'd0; m_load = 32'd0; m_presc = 16'd0;
        m_count = 32'd0; m_psc = 16'd0; m_exp = 1'b0; m_ovr = 1'b0; m_tick = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_load;
            2'd2:    return {16'd0, m_presc};
            default: return {29'd0, m_ovr, (m_mode == 1), m_exp};
        endcase
    endfunction

    task automatic model_step(input bit wr, input logic [1:0] a, input logic [31:0] d);
        bit cw, sw, expire, ovr_set;
        logic [3:0] ctrl_new;
        int mode_new;
        cw = wr && (a == 2'd0);
        sw = wr && (a == 2'd3);
        expire = 1'b0;
        ctrl_new = cw ? d[3:0] : m_ctrl;
        mode_new = m_mode;
        if (m_mode == 0) begin
            if (cw && d[0] && !m_ctrl[0]) begin
                m_count = m_load; m_psc = m_presc; mode_new = d[3] ? 2 : 1;
            end
        end else if (cw && !d[0]) begin
            mode_new = 0;
        end else if (m_mode == 2) begin
            if (cw && !d[3]) mode_new = 1;
        end else if (cw && d[3]) begin
            mode_new = 2;
        end else if (m_psc > 0) begin
            m_psc = m_psc - 16'd1;
        end else begin
            m_psc = m_presc;
            if (m_count > 0) m_count = m_count - 32'd1;
            else begin
                expire = 1'b1;
                if (m_ctrl[1]) m_count = m_load;
                else begin mode_new = 0; ctrl_new[0] = 1'b0; end
            end
        end
        ovr_set = expire && m_exp;
        if (sw && d[2]) m_ovr = 1'b0;
        if (ovr_set) m_ovr = 1'b1;
        if (sw && d[0]) m_exp = 1'b0;
        if (expire) m_exp = 1'b1;
        m_tick = expire;
        m_ctrl = ctrl_new;
        m_mode = mode_new;
        if (wr && a == 2'd1) m_load = d;
        if (wr && a == 2'd2) m_presc = d[15:0];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; outputs are compared against the model after the edge
    task automatic cycle(input bit wr, input logic [1:0] a, input logic [31:0] d);
        wr_en = wr; addr = a; wdata = d;
        @(posedge clk);
        model_step(wr, a, d);
        #1;
        check("m_count", count, m_count);
        check("m_tick", {31'd0, tick}, {31'd0, m_tick});
        check("m_busy", {31'd0, busy}, {31'd0, (m_mode == 1)});
        check("m_irq", {31'd0, irq}, {31'd0, (m_exp & m_ctrl[2])});
        check("m_rdata", rdata, model_read(a));
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        wr_en = 1'b0; addr = a; wdata = 32'd0;
        #1;
        check(name, rdata, exp);
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [31:0] e_count;
        logic        e_tick;
        logic        e_busy;
        logic        e_irq;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input bit wr, input logic [1:0] a, input logic [31:0] d,
                                input logic [31:0] c, input logic t, input logic b,
                                input logic i, input logic [31:0] r);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.e_count = c; v.e_tick = t;
        v.e_busy = b; v.e_irq = i; v.e_rdata = r;
        vt.push_back(v);
    endfunction

    initial begin
        reset = 1'b0; wr_en = 1'b0; addr = 2'd0; wdata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, "rst_rdata");
        #2 reset = 1'b1;

        // Periodic LOAD=3 PRESCALE=0, then one-shot LOAD=2 PRESCALE=1 with irq
        add(1, 2'd1, 32'd3, 32'd3 - 32'd3, 0, 0, 0, 32'd3);
        add(1, 2'd2, 32'd0, 32'd0, 0, 0, 0, 32'd0);
        add(1, 2'd0, 32'd3, 32'd3, 0, 1, 0, 32'd3);
        add(0, 2'd3, 32'd0, 32'd2, 0, 1, 0, 32'd2);
        add(0, 2'd3, 32'd0, 32'd1, 0, 1, 0, 32'd2);
        add(0, 2'd3, 32'd0, 32'd0, 0, 1, 0, 32'd2);
        add(0, 2'd3, 32'd0, 32'd3, 1, 1, 0, 32'd3);
        add(0, 2'd3, 32'd0, 32'd2, 0, 1, 0, 32'd3);
        add(0, 2'd3, 32'd0, 32'd1, 0, 1, 0, 32'd3);
        add(0, 2'd3, 32'd0, 32'd0, 0, 1, 0, 32'd3);
        add(0, 2'd3, 32'd0, 32'd3, 1, 1, 0, 32'd7);
        add(1, 2'd0, 32'd0, 32'd3, 0, 0, 0, 32'd0);
        add(1, 2'd3, 32'd5, 32'd3, 0, 0, 0, 32'd0);
        add(1, 2'd1, 32'd2, 32'd3, 0, 0, 0, 32'd2);
        add(1, 2'd2, 32'd1, 32'd3, 0, 0, 0, 32'd1);
        add(1, 2'd0, 32'd5, 32'd2, 0, 1, 0, 32'd5);
        add(0, 2'd3, 32'd0, 32'd2, 0, 1, 0, 32'd2);
        add(0, 2'd3, 32'd0, 32'd1, 0, 1, 0, 32'd2);
        add(0, 2'd3, 32'd0, 32'd1, 0, 1, 0, 32'd2);
        add(0, 2'd3, 32'd0, 32'd0, 0, 1, 0, 32'd2);
        add(0, 2'd3, 32'd0, 32'd0, 0, 1, 0, 32'd2);
        add(0, 2'd3, 32'd0, 32'd0, 1, 0, 1, 32'd1);
        add(0, 2'd0, 32'd0, 32'd0, 0, 0, 1, 32'd4);
        add(1, 2'd3, 32'd1, 32'd0, 0, 0, 0, 32'd0);
        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].wr, vt[i].a, vt[i].d);
            check($sformatf("vec%0d_count", i), count, vt[i].e_count);
            check($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, vt[i].e_tick});
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vt[i].e_busy});
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vt[i].e_irq});
            check($sformatf("vec%0d_rdata", i), rdata, vt[i].e_rdata);
        end

        // Expiry every cycle: overrun from the second expiry, set beats clear
        cycle(1, 2'd1, 32'd0);
        cycle(1, 2'd2, 32'd0);
        cycle(1, 2'd0, 32'd3);
        cycle(0, 2'd3, 32'd0);
        check("fast_tick1", {31'd0, tick}, 32'd1);
        check("fast_stat1", rdata, 32'd3);
        cycle(0, 2'd3, 32'd0);
        check("fast_stat2", rdata, 32'd7);
        cycle(1, 2'd3, 32'd5);
        check("clr_vs_set", rdata, 32'd7);
        cycle(1, 2'd0, 32'd0);
        check("dis_no_tick", {31'd0, tick}, 32'd0);
        rd(2'd3, 32'd5, "dis_status");
        cycle(1, 2'd3, 32'd5);
        check("clr_both", rdata, 32'd0);

        // Pause at count=5 for 10 cycles, then resume
        cycle(1, 2'd1, 32'd9);
        cycle(1, 2'd0, 32'd3);
        repeat (4) cycle(0, 2'd0, 32'd0);
        check("pre_pause", count, 32'd5);
        cycle(1, 2'd0, 32'd11);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 2'd3, 32'd0);
            check("pause_count", count, 32'd5);
            check("pause_busy", {31'd0, busy}, 32'd0);
        end
        cycle(1, 2'd0, 32'd3);
        cycle(0, 2'd0, 32'd0);
        check("resume_count", count, 32'd4);
        cycle(1, 2'd0, 32'd0);

        // LOAD rewritten mid-period applies at the next reload
        cycle(1, 2'd1, 32'd7);
        cycle(1, 2'd0, 32'd3);
        repeat (3) cycle(0, 2'd0, 32'd0);
        cycle(1, 2'd1, 32'd2);
        repeat (3) cycle(0, 2'd0, 32'd0);
        check("old_period_end", count, 32'd0);
        cycle(0, 2'd0, 32'd0);
        check("reload_new", count, 32'd2);
        check("reload_tick", {31'd0, tick}, 32'd1);
        repeat (2) cycle(0, 2'd0, 32'd0);
        cycle(0, 2'd0, 32'd0);
        check("reload_new2", count, 32'd2);
        cycle(1, 2'd0, 32'd0);

        // Asynchronous reset mid-count
        cycle(1, 2'd1, 32'd6);
        cycle(1, 2'd0, 32'd7);
        repeat (2) cycle(0, 2'd0, 32'd0);
        check("pre_rst_count", count, 32'd4);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        reset = 1'b0;
        #1;
        check("arst_count", count, 32'd0);
        check("arst_tick", {31'd0, tick}, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, "arst_rdata");
        model_reset();
        @(posedge clk);
        #2 reset = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            logic [1:0]  ra;
            logic [31:0] rdv;
            bit          rw;
            rw = ($urandom_range(0, 9) >= 6);
            ra = 2'($urandom_range(0, 3));
            case (ra)
                2'd0:    rdv = $urandom;
                2'd1:    rdv = 32'($urandom_range(0, 6));
                2'd2:    rdv = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
                default: rdv = $urandom;
            endcase
            cycle(rw, ra, rdv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
